// File: rtl/conv_pkg.sv
// Shared types for the convolution filter output path.
package conv_pkg;

  localparam int unsigned PIX_PER_BEAT = 4;

  // One beat of four lane pixels; lane 3 occupies the most significant byte.
  typedef struct packed {
    logic [7:0] pix3;
    logic [7:0] pix2;
    logic [7:0] pix1;
    logic [7:0] pix0;
  } beat_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } coll_state_t;

  // Sum of the four pixels of a beat; 4 x 255 fits in 10 bits.
  function automatic logic [9:0] beat_sum(beat_t b);
    return 10'(b.pix0) + 10'(b.pix1) + 10'(b.pix2) + 10'(b.pix3);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through head and same-cycle push/pop.
// A push into a full FIFO succeeds when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is a power of two).
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and occupancy registers; reset empties the FIFO immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/conv_out_collector.sv
// Collects four filtered pixels per valid cycle into 32-bit beats, buffers them and
// writes them to the result memory at sequential addresses, with a frame checksum.
module conv_out_collector
  import conv_pkg::*;
#(
  parameter int unsigned NUM_BEATS  = 16384,
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_pix0,
  input  logic [7:0]        in_pix1,
  input  logic [7:0]        in_pix2,
  input  logic [7:0]        in_pix3,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  input  logic              wr_gnt,
  output logic              busy,
  output logic              frame_done,
  output logic [31:0]       checksum,
  output logic              ovf
);

  localparam int unsigned CNT_W = $clog2(NUM_BEATS) + 1;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(NUM_BEATS);

  coll_state_t      state_q, state_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [31:0]      checksum_q, checksum_d;
  logic             ovf_q, ovf_d;

  beat_t       in_beat;
  logic [31:0] fifo_head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        accept;
  logic        push;
  logic        pop;
  logic        drop;

  assign in_beat = {in_pix3, in_pix2, in_pix1, in_pix0};

  // A beat is counted whenever it arrives in RUN; it only reaches the FIFO if
  // there is room, where a same-cycle pop frees a slot.
  assign accept = (state_q == RUN) && in_valid;
  assign pop    = wr_en && wr_gnt;
  assign push   = accept && (!fifo_full || pop);
  assign drop   = accept && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_beat),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next-state for the frame FSM, beat counters, checksum and overflow flag.
  always_comb begin
    state_d    = state_q;
    in_cnt_d   = in_cnt_q;
    wr_cnt_d   = pop ? (wr_cnt_q + CNT_W'(1)) : wr_cnt_q;
    checksum_d = checksum_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          in_cnt_d   = '0;
          wr_cnt_d   = '0;
          checksum_d = '0;
          ovf_d      = 1'b0;
        end
      end
      RUN: begin
        if (accept) begin
          in_cnt_d   = in_cnt_q + CNT_W'(1);
          checksum_d = checksum_q + 32'(beat_sum(in_beat));
          if (drop) begin
            ovf_d = 1'b1;
          end
          // Last beat is accepted in the same cycle the FSM leaves RUN.
          if (in_cnt_d == LastCnt) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // A dropped beat keeps wr_cnt short of LastCnt, holding the FSM here until rst.
        if (fifo_empty && (wr_cnt_q == LastCnt)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Frame state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      in_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      checksum_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_cnt_q   <= in_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      checksum_q <= checksum_d;
      ovf_q      <= ovf_d;
    end
  end

  // Memory write port and status outputs; wr_data reads as zero while nothing is queued.
  always_comb begin
    wr_en      = !fifo_empty;
    wr_data    = wr_en ? fifo_head : 32'h0;
    wr_addr    = ADDR_W'(wr_cnt_q);
    busy       = (state_q == RUN) || (state_q == DRAIN);
    frame_done = (state_q == DONE);
    checksum   = checksum_q;
    ovf        = ovf_q;
  end

endmodule

// File: tb/tb_conv_out_collector.sv
// Randomized self-checking bench for conv_out_collector against a queue-based frame model.
module tb_conv_out_collector;

  localparam int unsigned N     = 16;
  localparam int unsigned AW    = 15;
  localparam int unsigned DEPTH = 8;

  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [7:0]    p0, p1, p2, p3;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          wr_gnt;
  logic          busy;
  logic          frame_done;
  logic [31:0]   checksum;
  logic          ovf;

  always #5 clk = ~clk;

  conv_out_collector #(
    .NUM_BEATS  (N),
    .ADDR_W     (AW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_pix0    (p0),
    .in_pix1    (p1),
    .in_pix2    (p2),
    .in_pix3    (p3),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_gnt     (wr_gnt),
    .busy       (busy),
    .frame_done (frame_done),
    .checksum   (checksum),
    .ovf        (ovf)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Frame model: phase, counters, queued beats, checksum and overflow flag.
  int          m_phase;
  int          m_in_cnt;
  int          m_wr_cnt;
  logic [31:0] m_q[$];
  logic [31:0] m_sum;
  bit          m_ovf;

  int cyc      = 0;
  int done_cyc = -1;
  bit seen     = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_phase  = P_IDLE;
    m_in_cnt = 0;
    m_wr_cnt = 0;
    m_q.delete();
    m_sum    = 0;
    m_ovf    = 0;
  endtask

  // Advance the model by one clock edge given the inputs presented before it.
  task automatic model_step(input bit s, input bit v, input bit g, input logic [31:0] d);
    int sz;
    bit pop_now;
    bit push_now;
    sz       = m_q.size();
    pop_now  = (sz > 0) && g;
    push_now = 0;
    case (m_phase)
      P_IDLE: begin
        if (s) begin
          m_phase  = P_RUN;
          m_in_cnt = 0;
          m_wr_cnt = 0;
          m_sum    = 0;
          m_ovf    = 0;
        end
      end
      P_RUN: begin
        if (v) begin
          m_in_cnt++;
          m_sum = m_sum + 32'(d[7:0]) + 32'(d[15:8]) + 32'(d[23:16]) + 32'(d[31:24]);
          if ((sz < DEPTH) || pop_now) push_now = 1;
          else m_ovf = 1;
          if (m_in_cnt == N) m_phase = P_DRAIN;
        end
      end
      P_DRAIN: begin
        if (sz == 0 && m_wr_cnt == N) m_phase = P_DONE;
      end
      default: m_phase = P_IDLE;
    endcase
    if (pop_now) begin
      void'(m_q.pop_front());
      m_wr_cnt++;
    end
    if (push_now) m_q.push_back(d);
  endtask

  task automatic check_outputs();
    check_eq("wr_en", 32'(wr_en), 32'(m_q.size() > 0));
    if (m_q.size() > 0) check_eq("wr_data", wr_data, m_q[0]);
    check_eq("wr_addr", 32'(wr_addr), 32'(m_wr_cnt));
    check_eq("busy", 32'(busy), 32'((m_phase == P_RUN) || (m_phase == P_DRAIN)));
    check_eq("frame_done", 32'(frame_done), 32'(m_phase == P_DONE));
    check_eq("checksum", checksum, m_sum);
    check_eq("ovf", 32'(ovf), 32'(m_ovf));
    if (frame_done === 1'b1) begin
      seen     = 1;
      done_cyc = cyc;
    end
  endtask

  // One clock: check outputs at the falling edge, then drive the next inputs.
  task automatic cycle(input bit s, input bit v, input bit g, input logic [31:0] d);
    @(negedge clk);
    cyc++;
    check_outputs();
    start    = s;
    in_valid = v;
    wr_gnt   = g;
    {p3, p2, p1, p0} = d;
    model_step(s, v, g, d);
  endtask

  task automatic run_to_idle(input int budget);
    seen = 0;
    for (int k = 0; k < budget && m_phase != P_IDLE; k++) cycle(0, 0, 1, 32'h0);
    cycle(0, 0, 1, 32'h0);
    check_eq("frame_done_seen", 32'(seen), 32'd1);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic apply_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_wr_en", 32'(wr_en), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    start    = 1'b0;
    in_valid = 1'b0;
    wr_gnt   = 1'b0;
    model_clear();
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    int          t0;
    logic [31:0] saved;
    bit          v;
    bit          g;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    wr_gnt   = 1'b0;
    {p3, p2, p1, p0} = 32'h0;
    model_clear();

    // Reset values.
    repeat (2) @(negedge clk);
    check_eq("reset_wr_en", 32'(wr_en), 32'd0);
    check_eq("reset_wr_data", wr_data, 32'd0);
    check_eq("reset_wr_addr", 32'(wr_addr), 32'd0);
    check_eq("reset_checksum", checksum, 32'd0);
    check_eq("reset_frame_done", 32'(frame_done), 32'd0);
    #2 rst = 1'b0;

    // Back-to-back frame of identical beats with the write port always granted.
    cycle(1, 0, 1, 32'h0);
    t0 = cyc;
    for (int i = 0; i < N; i++) cycle(0, 1, 1, 32'h04030201);
    run_to_idle(50);
    check_eq("done_latency", 32'(done_cyc - t0), 32'(N + 3));
    check_eq("checksum_a", checksum, 32'(N * 10));

    // in_valid in IDLE is ignored and the checksum stays frozen.
    saved = checksum;
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, $urandom);
    check_eq("idle_checksum", checksum, saved);

    // Random frames with random valid/grant and stray start pulses during RUN.
    for (int f = 0; f < 3; f++) begin
      cycle(1, 0, 1, 32'h0);
      for (int k = 0; k < 400 && m_phase == P_RUN; k++) begin
        v = ($urandom_range(0, 9) < 7);
        g = ($urandom_range(0, 9) < 6) || (m_q.size() >= DEPTH - 1);
        cycle(($urandom_range(0, 7) == 0), v, g, $urandom);
      end
      run_to_idle(50);
      check_eq("rand_ovf", 32'(ovf), 32'd0);
    end

    // Stall: 8 beats fill the FIFO while ungranted, then flow resumes.
    cycle(1, 0, 0, 32'h0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, $urandom);
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, 32'h0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 1, $urandom);
    run_to_idle(50);
    check_eq("stall_ovf", 32'(ovf), 32'd0);

    // Overflow: 9th beat during the stall is dropped; frame stays in DRAIN.
    cycle(1, 0, 0, 32'h0);
    for (int i = 0; i < 9; i++) cycle(0, 1, 0, $urandom);
    for (int i = 0; i < 7; i++) cycle(0, 1, 1, $urandom);
    seen = 0;
    for (int i = 0; i < 40; i++) cycle(0, 0, 1, 32'h0);
    check_eq("ovf_set", 32'(ovf), 32'd1);
    check_eq("ovf_busy", 32'(busy), 32'd1);
    check_eq("ovf_no_done", 32'(seen), 32'd0);
    apply_reset();

    // Mid-frame reset with three beats buffered, then a clean all-0xFF frame.
    cycle(1, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, $urandom);
    apply_reset();
    cycle(1, 0, 1, 32'h0);
    for (int i = 0; i < N; i++) cycle(0, 1, 1, 32'hFFFF_FFFF);
    run_to_idle(50);
    check_eq("checksum_ff", checksum, 32'(N * 1020));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
